// File: rtl/display_window_scan_if.sv
// Bundle between the hash core / front panel (master) and the window scanner (slave).
// Widths must match the display_window_scan instance they connect to.
interface display_window_scan_if #(
    parameter int DATA_W = 128,
    parameter int WIN_W  = 16,
    parameter int NORM_W = 8,
    parameter int CTRL_W = 4
) ();
    logic [DATA_W-1:0] hash_in;
    logic              hash_valid;
    logic              mode;
    logic [CTRL_W-1:0] control;
    logic [NORM_W-1:0] normal;
    logic [WIN_W-1:0]  display_out;
    logic [CTRL_W-1:0] win_idx;
    logic              hash_loaded;
    logic              frame_done;

    modport master (
        output hash_in, hash_valid, mode, control, normal,
        input  display_out, win_idx, hash_loaded, frame_done
    );

    modport slave (
        input  hash_in, hash_valid, mode, control, normal,
        output display_out, win_idx, hash_loaded, frame_done
    );
endinterface

// File: rtl/display_window_scan.sv
// Snapshot a wide result and show one WIN_W window of it, manual or auto-scrolled.
// Define DISPLAY_BLANK_EN to insert a BLANK_CYC-cycle blank gap after each window.
module display_window_scan #(
    parameter int DATA_W    = 128,
    parameter int WIN_W     = 16,
    parameter int NORM_W    = 8,
    parameter int CTRL_W    = 4,
    parameter int DWELL     = 50000000,
    parameter int BLANK_CYC = 5000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    display_window_scan_if.slave bus
);
    localparam int NUM_WIN = DATA_W / WIN_W;
    localparam int CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

`ifdef DISPLAY_BLANK_EN
    typedef enum logic [1:0] {ST_MANUAL, ST_SCAN, ST_BLANK} state_t;
`else
    typedef enum logic [1:0] {ST_MANUAL, ST_SCAN} state_t;
`endif

    state_t            r_state;
    logic [DATA_W-1:0] r_snap;
    logic              r_loaded;
    logic [CNT_W-1:0]  r_cnt;
    logic [CTRL_W-1:0] r_idx;
    logic [WIN_W-1:0]  r_disp;
    logic [CTRL_W-1:0] r_widx;
    logic              r_fdone;

    state_t            w_state_nx;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [CTRL_W-1:0] w_idx_nx;
    logic [WIN_W-1:0]  w_disp_nx;
    logic [CTRL_W-1:0] w_widx_nx;
    logic              w_fdone_nx;
    logic [WIN_W-1:0]  w_man_disp;
    logic [CTRL_W-1:0] w_man_widx;
    logic [DATA_W-1:0] w_src;
    logic [WIN_W-1:0]  w_src_w1;
    logic              w_last;
    logic [CTRL_W-1:0] w_idx_adv;

    // Window k is 1-based; anything outside 1..NUM_WIN reads as blank.
    function automatic logic [WIN_W-1:0] f_win(
        input logic [DATA_W-1:0] s,
        input logic [CTRL_W-1:0] k
    );
        logic [WIN_W-1:0] o;
        o = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (k == CTRL_W'(i + 1)) o = s[i*WIN_W +: WIN_W];
        end
        return o;
    endfunction

    always_comb begin
        w_man_disp = WIN_W'(bus.normal);
        w_man_widx = '0;
        if (bus.control != '0) begin
            w_man_disp = f_win(r_snap, bus.control);
            if (bus.control <= CTRL_W'(NUM_WIN)) w_man_widx = bus.control;
        end
    end

    // A restart shows window 1 of the data being captured this very edge.
    assign w_src     = bus.hash_valid ? bus.hash_in : r_snap;
    assign w_src_w1  = f_win(w_src, CTRL_W'(1));
    assign w_last    = (r_idx == CTRL_W'(NUM_WIN));
    assign w_idx_adv = w_last ? CTRL_W'(1) : r_idx + CTRL_W'(1);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = '0;
        w_idx_nx   = r_idx;
        w_disp_nx  = r_disp;
        w_widx_nx  = r_widx;
        w_fdone_nx = 1'b0;
        if (r_state != ST_MANUAL && !bus.mode) begin
            w_state_nx = ST_MANUAL;
            w_idx_nx   = '0;
            w_disp_nx  = w_man_disp;
            w_widx_nx  = w_man_widx;
        end else if (r_state != ST_MANUAL && bus.hash_valid) begin
            w_state_nx = ST_SCAN;
            w_idx_nx   = CTRL_W'(1);
            w_disp_nx  = w_src_w1;
            w_widx_nx  = CTRL_W'(1);
        end else begin
            unique case (r_state)
                ST_MANUAL: begin
                    w_idx_nx  = '0;
                    w_widx_nx = '0;
                    if (bus.mode && r_loaded) begin
                        w_state_nx = ST_SCAN;
                        w_idx_nx   = CTRL_W'(1);
                        w_disp_nx  = w_src_w1;
                        w_widx_nx  = CTRL_W'(1);
                    end else if (bus.mode) begin
                        w_disp_nx = WIN_W'(bus.normal);
                    end else begin
                        w_disp_nx = w_man_disp;
                        w_widx_nx = w_man_widx;
                    end
                end
                ST_SCAN: begin
                    if (r_cnt == CNT_W'(DWELL - 1)) begin
`ifdef DISPLAY_BLANK_EN
                        w_state_nx = ST_BLANK;
                        w_disp_nx  = '0;
                        w_widx_nx  = '0;
`else
                        w_idx_nx   = w_idx_adv;
                        w_disp_nx  = f_win(r_snap, w_idx_adv);
                        w_widx_nx  = w_idx_adv;
                        w_fdone_nx = w_last;
`endif
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
`ifdef DISPLAY_BLANK_EN
                ST_BLANK: begin
                    if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
                        w_state_nx = ST_SCAN;
                        w_idx_nx   = w_idx_adv;
                        w_disp_nx  = f_win(r_snap, w_idx_adv);
                        w_widx_nx  = w_idx_adv;
                        w_fdone_nx = w_last;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    w_state_nx = ST_MANUAL;
                    w_idx_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_MANUAL;
            r_snap   <= '0;
            r_loaded <= 1'b0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_disp   <= '0;
            r_widx   <= '0;
            r_fdone  <= 1'b0;
        end else begin
            if (bus.hash_valid) begin
                r_snap   <= bus.hash_in;
                r_loaded <= 1'b1;
            end
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_disp  <= w_disp_nx;
            r_widx  <= w_widx_nx;
            r_fdone <= w_fdone_nx;
        end
    end

    assign bus.display_out = r_disp;
    assign bus.win_idx     = r_widx;
    assign bus.hash_loaded = r_loaded;
    assign bus.frame_done  = r_fdone;
endmodule

// File: tb/tb_display_window_scan.sv
// Scoreboard bench for display_window_scan with DWELL=4, BLANK_CYC=2.
// Expected outputs are queued by the driver and popped by a monitor every cycle.
module tb_display_window_scan;
    localparam int DW = 4;
`ifdef DISPLAY_BLANK_EN
    localparam int PER = 6;
`else
    localparam int PER = 4;
`endif
    localparam int N_CAP = 12 * PER + 4;
    localparam logic [127:0] H1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] H2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  w;
        logic        f;
        logic        l;
        string       nm;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    exp_t q[$];
    exp_t e_m;

    logic [15:0] H1W [8] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC,
                             16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
    logic [15:0] H2W [8] = '{16'h8888, 16'h7777, 16'h6666, 16'h5555,
                             16'h4444, 16'h3333, 16'h2222, 16'h1111};

    display_window_scan_if #(
        .DATA_W(128), .WIN_W(16), .NORM_W(8), .CTRL_W(4)
    ) bus ();

    display_window_scan #(
        .DATA_W(128), .WIN_W(16), .NORM_W(8), .CTRL_W(4),
        .DWELL(DW), .BLANK_CYC(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic cyc(input logic [15:0] d, input logic [3:0] w,
                       input logic f, input logic l, input string nm);
        exp_t e;
        e.d = d; e.w = w; e.f = f; e.l = l; e.nm = nm;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Scan position n counted from the edge that shows window 1.
    function automatic void scan_exp(input bit sel, input int n,
                                     output logic [15:0] d,
                                     output logic [3:0] w,
                                     output logic f);
        int k;
        k = (n / PER) % 8;
        d = sel ? H2W[k] : H1W[k];
        w = 4'(k + 1);
        f = (n > 0) && (n % (8 * PER) == 0);
        if (n % PER >= DW) begin
            d = '0;
            w = '0;
        end
    endfunction

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e_m = q.pop_front();
            chk({e_m.nm, ".disp"}, bus.display_out, e_m.d);
            chk({e_m.nm, ".widx"}, 16'(bus.win_idx), 16'(e_m.w));
            chk({e_m.nm, ".fdone"}, 16'(bus.frame_done), 16'(e_m.f));
            chk({e_m.nm, ".loaded"}, 16'(bus.hash_loaded), 16'(e_m.l));
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, ".disp"}, bus.display_out, 16'h0);
        chk({nm, ".widx"}, 16'(bus.win_idx), 16'h0);
        chk({nm, ".fdone"}, 16'(bus.frame_done), 16'h0);
        chk({nm, ".loaded"}, 16'(bus.hash_loaded), 16'h0);
    endtask

    initial begin
        logic [15:0] d;
        logic [3:0]  w;
        logic        f;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.mode = 1'b0;
        bus.control = '0;
        bus.normal = 8'hA5;
        bus.hash_valid = 1'b0;
        bus.hash_in = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        bus.mode = 1'b1;
        bus.control = 4'd3;
        cyc(16'h00A5, 4'd0, 1'b0, 1'b0, "auto_unloaded");
        cyc(16'h00A5, 4'd0, 1'b0, 1'b0, "auto_unloaded");
        bus.hash_in = H1;
        bus.hash_valid = 1'b1;
        cyc(16'h00A5, 4'd0, 1'b0, 1'b1, "cap_edge");
        bus.hash_valid = 1'b0;
        for (int n = 0; n < N_CAP; n++) begin
            scan_exp(1'b0, n, d, w, f);
            cyc(d, w, f, 1'b1, "scan");
        end

        bus.hash_in = H2;
        bus.hash_valid = 1'b1;
        scan_exp(1'b1, 0, d, w, f);
        cyc(d, w, f, 1'b1, "cap_restart");
        bus.hash_valid = 1'b0;
        for (int m = 1; m <= 4; m++) begin
            scan_exp(1'b1, m, d, w, f);
            cyc(d, w, f, 1'b1, "restart");
        end
        bus.mode = 1'b0;
        bus.control = 4'd3;
        cyc(16'h6666, 4'd3, 1'b0, 1'b1, "exit_scan");

        bus.control = 4'd0;
        cyc(16'h00A5, 4'd0, 1'b0, 1'b1, "man_norm");
        bus.hash_in = H1;
        bus.hash_valid = 1'b1;
        bus.control = 4'd1;
        cyc(16'h8888, 4'd1, 1'b0, 1'b1, "man_old");
        bus.hash_valid = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            bus.control = 4'(c);
            if (c <= 8) cyc(H1W[c-1], 4'(c), 1'b0, 1'b1, "man_sel");
            else        cyc(16'h0, 4'd0, 1'b0, 1'b1, "man_blank");
        end

        bus.control = 4'd0;
        bus.mode = 1'b1;
        for (int n = 0; n < 2 * PER + 2; n++) begin
            scan_exp(1'b0, n, d, w, f);
            cyc(d, w, f, 1'b1, "scan2");
        end
        chk({"pre_rst", ".disp"}, bus.display_out, 16'hBA98);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        repeat (2) @(negedge clk);
        bus.mode = 1'b0;
        bus.control = 4'd0;
        bus.normal = 8'h5A;
        rst_n = 1'b1;
        cyc(16'h005A, 4'd0, 1'b0, 1'b0, "post_rst");
        @(negedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain left %0d required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
